data_memory_arbiter: RTL and testbench

- Shares one single-port data memory (combinational read, write on posedge clk) between NUM_PORTS requesters, e.g. cores on the interconnect.
- Round-robin arbitration, one access per cycle.
- Optional lock lets one requester keep the memory for back-to-back accesses.
- Read data is registered and returned to the winner one cycle after grant.

---
 rtl/data_memory_arbiter.sv | 172 +++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// ---------------------------------------------------------------------------
// data_memory_arbiter
// Shares one single-port data memory (combinational read, write on posedge
// clk) between NUM_PORTS requesters. Round-robin arbitration grants one
// access per cycle; a requester may lock the memory for back-to-back
// accesses. Read data is registered and returned one cycle after the grant.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   request_valid/write/lock  per-port request qualifiers (NUM_PORTS bits)
//   request_address/data  per-port payload, port i at [i*WIDTH +: WIDTH]
//   request_ready         one-hot grant, combinational from valids + state
//   response_valid        one-hot, registered; read data valid for that port
//   response_data         registered read data (holds when not valid)
//   memory_write_enable/address/data_in  combinational drive to the memory
//   memory_data_out       combinational read data from the memory
// ---------------------------------------------------------------------------
module data_memory_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PTR_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_PORTS-1:0]         request_valid,
    input  logic [NUM_PORTS-1:0]         request_write,
    input  logic [NUM_PORTS-1:0]         request_lock,
    input  logic [NUM_PORTS*WIDTH-1:0]   request_address,
    input  logic [NUM_PORTS*WIDTH-1:0]   request_data,
    output logic [NUM_PORTS-1:0]         request_ready,
    output logic [NUM_PORTS-1:0]         response_valid,
    output logic [WIDTH-1:0]             response_data,
    output logic                         memory_write_enable,
    output logic [WIDTH-1:0]             memory_address,
    output logic [WIDTH-1:0]             memory_data_in,
    input  logic [WIDTH-1:0]             memory_data_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [PTR_WIDTH-1:0]   owner_q, owner_d;
    logic [NUM_PORTS-1:0]   resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]       resp_data_q, resp_data_d;

    logic                   rr_found;
    logic [PTR_WIDTH-1:0]   rr_winner;
    logic                   grant;
    logic                   grant_c;
    logic [PTR_WIDTH-1:0]   grant_idx;

    // Increment a port index, wrapping NUM_PORTS-1 back to 0.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        if (p == PTR_WIDTH'(NUM_PORTS - 1)) begin
            return '0;
        end
        return p + PTR_WIDTH'(1);
    endfunction

    // Round-robin search: first valid port starting at the pointer.
    always_comb begin
        int unsigned idx;
        rr_found  = 1'b0;
        rr_winner = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!rr_found && request_valid[idx]) begin
                rr_found  = 1'b1;
                rr_winner = PTR_WIDTH'(idx);
            end
        end
    end

    // Next-state logic: grant selection, pointer and lock ownership.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant     = 1'b0;
        grant_idx = '0;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant     = 1'b1;
                    grant_idx = rr_winner;
                    ptr_d     = ptr_inc(rr_winner);
                    if (request_lock[rr_winner]) begin
                        state_d = LOCKED;
                        owner_d = rr_winner;
                    end
                end
            end
            LOCKED: begin
                // Only the owner may be served; an idle owner releases the lock.
                if (request_valid[owner_q]) begin
                    grant     = 1'b1;
                    grant_idx = owner_q;
                    if (!request_lock[owner_q]) begin
                        state_d = IDLE;
                        ptr_d   = ptr_inc(owner_q);
                    end
                end else begin
                    state_d = IDLE;
                    ptr_d   = ptr_inc(owner_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant is suppressed combinationally while reset is asserted.
    assign grant_c = grant & reset_n;

    // Ready vector and memory drive from the selected port.
    always_comb begin
        request_ready       = '0;
        memory_write_enable = 1'b0;
        memory_address      = '0;
        memory_data_in      = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_c && (grant_idx == PTR_WIDTH'(i))) begin
                request_ready[i]    = 1'b1;
                memory_write_enable = request_write[i];
                memory_address      = request_address[i*WIDTH +: WIDTH];
                memory_data_in      = request_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Read response capture: data sampled at the grant edge, valid for one cycle.
    always_comb begin
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_c && (grant_idx == PTR_WIDTH'(i)) && !request_write[i]) begin
                resp_valid_d[i] = 1'b1;
                resp_data_d     = memory_data_out;
            end
        end
    end

    // State and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign response_valid = resp_valid_q;
    assign response_data  = resp_data_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_memory_arbiter
// Directed bench for data_memory_arbiter with a behavioural single-port
// memory. Expected grants are given per step; expected read responses are
// pushed to a scoreboard queue at grant time and popped one cycle later.
// ---------------------------------------------------------------------------
module tb_data_memory_arbiter;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned NUM_PORTS = 4;

    logic                        clk;
    logic                        reset_n;
    logic                        mem_init_n;
    logic [NUM_PORTS-1:0]        request_valid;
    logic [NUM_PORTS-1:0]        request_write;
    logic [NUM_PORTS-1:0]        request_lock;
    logic [NUM_PORTS*WIDTH-1:0]  request_address;
    logic [NUM_PORTS*WIDTH-1:0]  request_data;
    logic [NUM_PORTS-1:0]        request_ready;
    logic [NUM_PORTS-1:0]        response_valid;
    logic [WIDTH-1:0]            response_data;
    logic                        memory_write_enable;
    logic [WIDTH-1:0]            memory_address;
    logic [WIDTH-1:0]            memory_data_in;
    logic [WIDTH-1:0]            memory_data_out;

    int checks;
    int failures;

    // Scoreboard of expected read responses.
    int              sb_port[$];
    logic [WIDTH-1:0] sb_data[$];
    logic [WIDTH-1:0] last_resp;

    // Reference memory contents (bench-side model).
    logic [WIDTH-1:0] ref_mem [256];
    logic             ref_wr  [256];

    data_memory_arbiter #(
        .WIDTH     (WIDTH),
        .NUM_PORTS (NUM_PORTS)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .request_valid       (request_valid),
        .request_write       (request_write),
        .request_lock        (request_lock),
        .request_address     (request_address),
        .request_data        (request_data),
        .request_ready       (request_ready),
        .response_valid      (response_valid),
        .response_data       (response_data),
        .memory_write_enable (memory_write_enable),
        .memory_address      (memory_address),
        .memory_data_in      (memory_data_in),
        .memory_data_out     (memory_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural memory: unwritten locations read as address ^ 0xA5.
    logic [WIDTH-1:0] mem [256];
    logic [255:0]     mem_wr;

    always @(posedge clk or negedge mem_init_n) begin
        if (!mem_init_n) begin
            mem_wr <= '0;
        end else if (memory_write_enable) begin
            mem_wr[memory_address] <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (mem_init_n && memory_write_enable) begin
            mem[memory_address] <= memory_data_in;
        end
    end

    assign memory_data_out = mem_wr[memory_address] ? mem[memory_address]
                                                    : (memory_address ^ 8'hA5);

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [WIDTH-1:0] ref_read(input logic [WIDTH-1:0] a);
        return ref_wr[a] ? ref_mem[a] : (a ^ 8'hA5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic w, input logic l,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        request_valid[p]               = v;
        request_write[p]               = w;
        request_lock[p]                = l;
        request_address[p*WIDTH +: WIDTH] = a;
        request_data[p*WIDTH +: WIDTH]    = d;
    endtask

    task automatic clear_ports();
        request_valid   = '0;
        request_write   = '0;
        request_lock    = '0;
        request_address = '0;
        request_data    = '0;
    endtask

    // One cycle: check pending response, check grant and memory drive, advance.
    task automatic step(input string tag, input logic [NUM_PORTS-1:0] exp_ready);
        logic [WIDTH-1:0]     ea;
        logic [WIDTH-1:0]     ed;
        logic                 ewe;
        logic [NUM_PORTS-1:0] oh;
        int                   p;
        logic [WIDTH-1:0]     d;
        if (sb_port.size() > 0) begin
            p  = sb_port.pop_front();
            d  = sb_data.pop_front();
            oh = NUM_PORTS'(1 << p);
            check({tag, ".resp_valid"}, 32'(response_valid), 32'(oh));
            check({tag, ".resp_data"}, 32'(response_data), 32'(d));
            last_resp = d;
        end else begin
            check({tag, ".resp_idle"}, 32'(response_valid), 32'd0);
            check({tag, ".resp_hold"}, 32'(response_data), 32'(last_resp));
        end
        #1;
        check({tag, ".ready"}, 32'(request_ready), 32'(exp_ready));
        ea  = '0;
        ed  = '0;
        ewe = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (exp_ready[i]) begin
                ea  = request_address[i*WIDTH +: WIDTH];
                ed  = request_data[i*WIDTH +: WIDTH];
                ewe = request_write[i];
                if (request_write[i]) begin
                    ref_mem[ea] = ed;
                    ref_wr[ea]  = 1'b1;
                end else begin
                    sb_port.push_back(i);
                    sb_data.push_back(ref_read(ea));
                end
            end
        end
        check({tag, ".mem_addr"}, 32'(memory_address), 32'(ea));
        check({tag, ".mem_din"}, 32'(memory_data_in), 32'(ed));
        check({tag, ".mem_we"}, 32'(memory_write_enable), 32'(ewe));
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset (with whatever inputs are driven), check forced outputs, release.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, ".rst_ready"}, 32'(request_ready), 32'd0);
        check({tag, ".rst_we"}, 32'(memory_write_enable), 32'd0);
        check({tag, ".rst_addr"}, 32'(memory_address), 32'd0);
        check({tag, ".rst_resp_valid"}, 32'(response_valid), 32'd0);
        check({tag, ".rst_resp_data"}, 32'(response_data), 32'd0);
        sb_port.delete();
        sb_data.delete();
        last_resp = '0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        last_resp = '0;
        reset_n   = 1'b0;
        mem_init_n = 1'b0;
        clear_ports();
        for (int a = 0; a < 256; a++) begin
            ref_wr[a]  = 1'b0;
            ref_mem[a] = '0;
        end
        #2 mem_init_n = 1'b1;
        @(negedge clk);

        // Reset with all ports requesting: no grant may escape.
        request_valid = 4'hF;
        do_reset("init");
        clear_ports();

        // Single port write then read-back of the same address.
        set_port(2, 1'b1, 1'b1, 1'b0, 8'h10, 8'h5A);
        step("p2_wr", 4'b0100);
        set_port(2, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        step("p2_rd", 4'b0100);
        clear_ports();
        step("p2_drain", 4'b0000);

        // All four ports hold reads from reset: round-robin 0,1,2,3,0.
        do_reset("rr");
        for (int i = 0; i < NUM_PORTS; i++) begin
            set_port(i, 1'b1, 1'b0, 1'b0, 8'(8'h20 + i), 8'h00);
        end
        step("rr0", 4'b0001);
        step("rr1", 4'b0010);
        step("rr2", 4'b0100);
        step("rr3", 4'b1000);
        step("rr4", 4'b0001);
        clear_ports();
        step("rr_drain", 4'b0000);

        // Port 1 locks for three writes while port 3 waits.
        do_reset("lock");
        set_port(3, 1'b1, 1'b0, 1'b0, 8'h31, 8'h00);
        set_port(1, 1'b1, 1'b1, 1'b1, 8'h30, 8'h11);
        step("lock_w0", 4'b0010);
        set_port(1, 1'b1, 1'b1, 1'b1, 8'h31, 8'h22);
        step("lock_w1", 4'b0010);
        set_port(1, 1'b1, 1'b1, 1'b0, 8'h32, 8'h33);
        step("lock_w2", 4'b0010);
        set_port(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step("lock_p3", 4'b1000);
        clear_ports();
        step("lock_drain", 4'b0000);

        // Lock owner drops valid: no grant that cycle, then waiting port 0.
        do_reset("drop");
        set_port(1, 1'b1, 1'b0, 1'b1, 8'h40, 8'h00);
        step("drop_lock", 4'b0010);
        set_port(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_port(0, 1'b1, 1'b0, 1'b0, 8'h41, 8'h00);
        step("drop_gap", 4'b0000);
        step("drop_p0", 4'b0001);
        clear_ports();
        step("drop_drain", 4'b0000);

        // Reset the cycle after a locked read grant: response dropped, lock released.
        set_port(2, 1'b1, 1'b0, 1'b1, 8'h50, 8'h00);
        step("mid_rd", 4'b0100);
        set_port(1, 1'b1, 1'b0, 1'b0, 8'h51, 8'h00);
        set_port(3, 1'b1, 1'b0, 1'b0, 8'h53, 8'h00);
        do_reset("mid");
        step("mid_after", 4'b0010);
        clear_ports();
        step("mid_drain", 4'b0000);

        // No requests: memory interface stays quiet.
        for (int i = 0; i < 5; i++) begin
            step($sformatf("quiet%0d", i), 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
